// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-hot row strobes, synchronised column sampling,
// press/release debounce and a single-cycle report per accepted key.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] col_i,
    output logic [3:0] row_o,
    output logic [3:0] key_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    col_meta_q;
    logic [3:0]    col_s_q;
    logic [3:0]    row_q, row_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] db_q, db_d;
    logic [1:0]    settle_q, settle_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;

    logic [3:0]    row_next;
    logic [1:0]    row_enc;
    logic [1:0]    col_pick;
    logic          tracked;

    // Two-flop synchroniser; col_i is asynchronous to clk_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_meta_q <= 4'b0000;
            col_s_q    <= 4'b0000;
        end else begin
            col_meta_q <= col_i;
            col_s_q    <= col_meta_q;
        end
    end

    assign row_next   = {row_q[2:0], row_q[3]};
    assign row_enc    = {row_q[2] | row_q[3], row_q[1] | row_q[3]};
    assign tracked    = col_s_q[col_idx_q];

    // Lowest set column wins when several are active.
    always_comb begin
        col_pick = 2'd0;
        if (col_s_q[0]) begin
            col_pick = 2'd0;
        end else if (col_s_q[1]) begin
            col_pick = 2'd1;
        end else if (col_s_q[2]) begin
            col_pick = 2'd2;
        end else if (col_s_q[3]) begin
            col_pick = 2'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        div_d       = div_q;
        db_d        = db_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        settle_d    = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;

        case (state_q)
            SCAN: begin
                // A press seen on the step cycle wins; the row stays put.
                if (settle_q == 2'd0 && col_s_q != 4'b0000) begin
                    row_idx_d = row_enc;
                    col_idx_d = col_pick;
                    db_d      = '0;
                    state_d   = DEBOUNCE;
                end else if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    row_d    = row_next;
                    settle_d = 2'd2;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!tracked) begin
                    state_d  = SCAN;
                    row_d    = row_next;
                    div_d    = '0;
                    settle_d = 2'd2;
                end else if (db_q == DB_LAST) begin
                    state_d     = HELD;
                    key_d       = {row_idx_q, col_idx_q};
                    key_valid_d = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            HELD: begin
                if (!tracked) begin
                    state_d = RELEASE;
                    db_d    = '0;
                end
            end
            RELEASE: begin
                // Bounce back to pressed re-enters HELD without a new report.
                if (tracked) begin
                    state_d = HELD;
                    db_d    = '0;
                end else if (db_q == DB_LAST) begin
                    state_d  = SCAN;
                    row_d    = row_next;
                    div_d    = '0;
                    settle_d = 2'd2;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SCAN;
            row_q       <= 4'b0001;
            div_q       <= '0;
            db_q        <= '0;
            settle_q    <= 2'd0;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            div_q       <= div_d;
            db_q        <= db_d;
            settle_q    <= settle_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign row_o       = row_q;
    assign key_o       = key_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = (state_q == HELD) || (state_q == RELEASE);

endmodule
